// File: rtl/sdram_arbit_pkg.sv
// sdram_para: encodings shared by the SDRAM sub-controllers (init, auto-refresh,
// write, read) and by the arbiter that multiplexes them onto the pins.
// Commands are {cs_n, ras_n, cas_n, we_n}.
package sdram_para;

    localparam int CMD_W  = 4;
    localparam int ADDR_W = 13;
    localparam int BANK_W = 2;

    localparam logic [CMD_W-1:0] CMD_NOP  = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_PALL = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_AREF = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_MRS  = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_ACT  = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_WR   = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_RD   = 4'b0101;

    // Arbiter states
    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_ARBIT = 3'd1,
        S_AREF  = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/sdram_arbit_if.sv
// sdram_arbit_if: bundle between the SDRAM sub-controllers and the arbiter.
//   init_*  : init sequencer command/address and its done level
//   aref_*  : refresh request pulse, end pulse, command/address
//   wr_*    : writer request level, end pulse, command/address/bank
//   rd_*    : reader request level, end pulse, command/address/bank
//   *_en    : per-controller grant, ref_pend : refresh waiting
//   sdram_* : registered SDRAM command/address/bank pins
// modport master = sub-controller side, modport slave = arbiter side.
interface sdram_arbit_if;
    import sdram_para::*;

    logic                flag_init_end;
    logic [CMD_W-1:0]    init_cmd;
    logic [ADDR_W-1:0]   init_addr;

    logic                aref_req;
    logic                flag_aref_end;
    logic [CMD_W-1:0]    aref_cmd;
    logic [ADDR_W-1:0]   aref_addr;

    logic                wr_req;
    logic                flag_wr_end;
    logic [CMD_W-1:0]    wr_cmd;
    logic [ADDR_W-1:0]   wr_addr;
    logic [BANK_W-1:0]   wr_bank;

    logic                rd_req;
    logic                flag_rd_end;
    logic [CMD_W-1:0]    rd_cmd;
    logic [ADDR_W-1:0]   rd_addr;
    logic [BANK_W-1:0]   rd_bank;

    logic                aref_en;
    logic                wr_en;
    logic                rd_en;
    logic                ref_pend;

    logic [CMD_W-1:0]    sdram_cmd;
    logic [ADDR_W-1:0]   sdram_addr;
    logic [BANK_W-1:0]   sdram_bank;

    modport master (
        output flag_init_end, init_cmd, init_addr,
        output aref_req, flag_aref_end, aref_cmd, aref_addr,
        output wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank,
        output rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
        input  aref_en, wr_en, rd_en, ref_pend,
        input  sdram_cmd, sdram_addr, sdram_bank
    );

    modport slave (
        input  flag_init_end, init_cmd, init_addr,
        input  aref_req, flag_aref_end, aref_cmd, aref_addr,
        input  wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank,
        input  rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
        output aref_en, wr_en, rd_en, ref_pend,
        output sdram_cmd, sdram_addr, sdram_bank
    );

endinterface

// File: rtl/sdram_arbit.sv
// sdram_arbit: holds traffic until init completes, latches refresh requests,
// grants one sub-controller at a time (refresh > write > read) and registers
// the granted controller's command/address/bank onto the SDRAM pins.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   sif   : sdram_arbit_if.slave (requests/commands in, grants/pins out)
module sdram_arbit
    import sdram_para::*;
(
    input  logic          clk,
    input  logic          rst_n,
    sdram_arbit_if.slave  sif
);

    arb_state_t          r_state;
    arb_state_t          w_next;
    logic                r_ref_pend;

    logic [CMD_W-1:0]    w_cmd;
    logic [ADDR_W-1:0]   w_addr;
    logic [BANK_W-1:0]   w_bank;
    logic [CMD_W-1:0]    r_cmd;
    logic [ADDR_W-1:0]   r_addr;
    logic [BANK_W-1:0]   r_bank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_INIT;
        else        r_state <= w_next;
    end

    // End flags only matter in the state they belong to.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:  if (sif.flag_init_end) w_next = S_ARBIT;
            S_ARBIT: begin
                if      (r_ref_pend) w_next = S_AREF;
                else if (sif.wr_req) w_next = S_WRITE;
                else if (sif.rd_req) w_next = S_READ;
            end
            S_AREF:  if (sif.flag_aref_end) w_next = S_ARBIT;
            S_WRITE: if (sif.flag_wr_end)   w_next = S_ARBIT;
            S_READ:  if (sif.flag_rd_end)   w_next = S_ARBIT;
            default: w_next = S_INIT;
        endcase
    end

    // Refresh pending: a new request wins over the clear on the grant edge,
    // so a request landing on that edge is served as a second refresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ref_pend <= 1'b0;
        else if (sif.aref_req && r_state != S_INIT)
            r_ref_pend <= 1'b1;
        else if (r_state == S_ARBIT && r_ref_pend)
            r_ref_pend <= 1'b0;
    end

    always_comb begin
        w_cmd  = CMD_NOP;
        w_addr = '0;
        w_bank = '0;
        case (r_state)
            S_INIT:  begin w_cmd = sif.init_cmd; w_addr = sif.init_addr; end
            S_AREF:  begin w_cmd = sif.aref_cmd; w_addr = sif.aref_addr; end
            S_WRITE: begin w_cmd = sif.wr_cmd; w_addr = sif.wr_addr; w_bank = sif.wr_bank; end
            S_READ:  begin w_cmd = sif.rd_cmd; w_addr = sif.rd_addr; w_bank = sif.rd_bank; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd  <= CMD_NOP;
            r_addr <= '0;
            r_bank <= '0;
        end else begin
            r_cmd  <= w_cmd;
            r_addr <= w_addr;
            r_bank <= w_bank;
        end
    end

    assign sif.aref_en    = (r_state == S_AREF);
    assign sif.wr_en      = (r_state == S_WRITE);
    assign sif.rd_en      = (r_state == S_READ);
    assign sif.ref_pend   = r_ref_pend;
    assign sif.sdram_cmd  = r_cmd;
    assign sif.sdram_addr = r_addr;
    assign sif.sdram_bank = r_bank;

endmodule

// File: tb/tb_sdram_arbit.sv
// Randomised bench for sdram_arbit. A driver emulates the sub-controllers and
// feeds a behavioural reference; expected post-edge outputs go into a queue
// that a negedge monitor pops and compares against the DUT.
module tb_sdram_arbit;
    import sdram_para::*;

    typedef struct packed {
        logic        aref_en;
        logic        wr_en;
        logic        rd_en;
        logic        ref_pend;
        logic [3:0]  cmd;
        logic [12:0] addr;
        logic [1:0]  bank;
    } exp_t;

    localparam int NCYC = 3000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    sdram_arbit_if sif();

    sdram_arbit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    int   vectors = 0;
    int   miscompares = 0;
    exp_t q[$];

    // Reference: who owns the pins (0 none, 1 refresh, 2 write, 3 read),
    // whether init has finished, and whether a refresh is owed.
    bit          m_init_done;
    int          m_owner;
    bit          m_pend;
    logic [3:0]  m_cmd;
    logic [12:0] m_addr;
    logic [1:0]  m_bank;

    function automatic void model_clear();
        m_init_done = 1'b0;
        m_owner     = 0;
        m_pend      = 1'b0;
        m_cmd       = 4'b0111;
        m_addr      = '0;
        m_bank      = '0;
    endfunction

    // Advance the reference across one rising edge using the current inputs.
    function automatic void model_step();
        exp_t e;
        bit   new_pend;
        if (!rst_n) begin
            model_clear();
        end else begin
            if (!m_init_done) begin
                m_cmd = sif.init_cmd; m_addr = sif.init_addr; m_bank = 2'd0;
            end else if (m_owner == 1) begin
                m_cmd = sif.aref_cmd; m_addr = sif.aref_addr; m_bank = 2'd0;
            end else if (m_owner == 2) begin
                m_cmd = sif.wr_cmd; m_addr = sif.wr_addr; m_bank = sif.wr_bank;
            end else if (m_owner == 3) begin
                m_cmd = sif.rd_cmd; m_addr = sif.rd_addr; m_bank = sif.rd_bank;
            end else begin
                m_cmd = 4'b0111; m_addr = '0; m_bank = 2'd0;
            end

            new_pend = m_pend;
            if (m_init_done && m_owner == 0 && m_pend) new_pend = 1'b0;
            if (m_init_done && sif.aref_req)           new_pend = 1'b1;

            if (!m_init_done) begin
                m_init_done = sif.flag_init_end;
            end else if (m_owner == 0) begin
                if (m_pend)           m_owner = 1;
                else if (sif.wr_req)  m_owner = 2;
                else if (sif.rd_req)  m_owner = 3;
            end else if (m_owner == 1 && sif.flag_aref_end) m_owner = 0;
            else if (m_owner == 2 && sif.flag_wr_end)       m_owner = 0;
            else if (m_owner == 3 && sif.flag_rd_end)       m_owner = 0;
            m_pend = new_pend;
        end
        e.aref_en  = m_init_done && m_owner == 1;
        e.wr_en    = m_init_done && m_owner == 2;
        e.rd_en    = m_init_done && m_owner == 3;
        e.ref_pend = m_pend;
        e.cmd      = m_cmd;
        e.addr     = m_addr;
        e.bank     = m_bank;
        q.push_back(e);
    endfunction

    // Monitor: compare the outputs produced by the last edge.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {sif.aref_en, sif.wr_en, sif.rd_en, sif.ref_pend,
                 sif.sdram_cmd, sif.sdram_addr, sif.sdram_bank};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL outputs t=%0t actual en(a/w/r)=%b%b%b pend=%b cmd=%b addr=%h bank=%0d required en=%b%b%b pend=%b cmd=%b addr=%h bank=%0d",
                         $time, a.aref_en, a.wr_en, a.rd_en, a.ref_pend, a.cmd, a.addr, a.bank,
                         e.aref_en, e.wr_en, e.rd_en, e.ref_pend, e.cmd, e.addr, e.bank);
            end
        end
    end

    task automatic check_now(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    initial begin
        bit wr_job, rd_job;
        int prev_owner, svc_cnt, svc_len;
        int init_cnt, init_len, aref_gap, rst_hold, next_rst, n_rst;
        bit end_now;

        model_clear();
        wr_job = 0; rd_job = 0; prev_owner = 0; svc_cnt = 0; svc_len = 8;
        init_cnt = 0; init_len = 4; aref_gap = 60; rst_hold = 2;
        next_rst = 900; n_rst = 0;

        sif.flag_init_end = 1'b0; sif.init_cmd = 4'b0010; sif.init_addr = 13'h400;
        sif.aref_req = 1'b0; sif.flag_aref_end = 1'b0; sif.aref_cmd = CMD_AREF; sif.aref_addr = '0;
        sif.wr_req = 1'b0; sif.flag_wr_end = 1'b0; sif.wr_cmd = CMD_NOP; sif.wr_addr = '0; sif.wr_bank = '0;
        sif.rd_req = 1'b0; sif.flag_rd_end = 1'b0; sif.rd_cmd = CMD_NOP; sif.rd_addr = '0; sif.rd_bank = '0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            #1;
            // Reset: at start, and mid-read twice (forced if no read shows up).
            if (rst_hold > 0) begin
                rst_n = 1'b0;
                rst_hold--;
            end else if (n_rst < 2 && cyc >= next_rst && (m_owner == 3 || cyc >= next_rst + 400)) begin
                rst_n = 1'b0;
                #1;
                check_now("reset_rd_en",    {31'd0, sif.rd_en},    32'd0);
                check_now("reset_cmd",      {28'd0, sif.sdram_cmd}, {28'd0, CMD_NOP});
                check_now("reset_ref_pend", {31'd0, sif.ref_pend}, 32'd0);
                rst_hold = 1;
                n_rst++;
                next_rst = cyc + 900;
            end else begin
                rst_n = 1'b1;
            end
            if (!rst_n) begin
                wr_job = 0; rd_job = 0; prev_owner = 0; svc_cnt = 0;
                init_cnt = 0; init_len = $urandom_range(2, 8);
            end

            // Random payloads; the first init cycles use a fixed PALL pattern.
            if (init_cnt < 3) begin
                sif.init_cmd = 4'b0010; sif.init_addr = 13'h400;
            end else begin
                sif.init_cmd = 4'($urandom); sif.init_addr = 13'($urandom);
            end
            sif.aref_cmd = 4'($urandom); sif.aref_addr = 13'($urandom);
            sif.wr_cmd = 4'($urandom); sif.wr_addr = 13'($urandom); sif.wr_bank = 2'($urandom);
            sif.rd_cmd = 4'($urandom); sif.rd_addr = 13'($urandom); sif.rd_bank = 2'($urandom);

            if (rst_n) init_cnt++;
            sif.flag_init_end = rst_n && (m_init_done || init_cnt > init_len);

            // Service length per grant; the owner raises its end flag on the last cycle.
            if (m_init_done && m_owner != 0) begin
                if (m_owner == prev_owner) svc_cnt++;
                else begin
                    svc_cnt = 0;
                    svc_len = (m_owner == 1) ? 8 : $urandom_range(2, 12);
                end
            end
            prev_owner = m_init_done ? m_owner : 0;
            end_now = m_init_done && m_owner != 0 && svc_cnt == svc_len - 1;

            sif.flag_aref_end = (m_owner == 1 && end_now) || (m_owner != 1 && $urandom_range(0, 9) == 0);
            sif.flag_wr_end   = (m_owner == 2 && end_now) || (m_owner != 2 && $urandom_range(0, 9) == 0);
            sif.flag_rd_end   = (m_owner == 3 && end_now) || (m_owner != 3 && $urandom_range(0, 9) == 0);

            if (m_owner == 2 && end_now) wr_job = 0;
            if (m_owner == 3 && end_now) rd_job = 0;
            if (rst_n && !wr_job && $urandom_range(0, 7) == 0) wr_job = 1;
            if (rst_n && !rd_job && $urandom_range(0, 5) == 0) rd_job = 1;
            sif.wr_req = wr_job && !(m_init_done && m_owner == 2);
            sif.rd_req = rd_job && !(m_init_done && m_owner == 3);

            // Refresh pulses: periodic after init, occasionally on the grant
            // edge itself, and random (to be dropped) before init.
            sif.aref_req = 1'b0;
            if (!m_init_done) begin
                sif.aref_req = ($urandom_range(0, 4) == 0);
            end else begin
                aref_gap--;
                if (aref_gap <= 0 || (m_owner == 0 && m_pend && $urandom_range(0, 2) == 0)) begin
                    sif.aref_req = 1'b1;
                    aref_gap = $urandom_range(40, 90);
                end
            end

            model_step();
        end
        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
